// File: rtl/fetch_unit_pkg.sv
// Shared constants, FSM state encoding and hold-buffer layout for the
// instruction fetch stage.
package fetch_unit_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_EXC   = 32'h0000_4180;
  localparam logic [31:0] IMEM_LO  = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI  = 32'h0000_6FFC;
  localparam logic [4:0]  EXC_ADEL = 5'd4;
  localparam logic [4:0]  EXC_NONE = 5'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_e;

  // Instruction parked in F while D is stalled, or a synthesized AdEL.
  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  exccode;
  } fetch_hold_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel: one outstanding request,
// response arrives on imem_rvalid at least one cycle after imem_req.
interface fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit_pc_legal_check.sv
// Combinational fetch-address legality test: word aligned and inside the
// instruction memory window.
module pc_legal_check
  import fetch_unit_pkg::*;
(
  input  logic [31:0] addr,
  output logic        legal
);

  assign legal = (addr[1:0] == 2'b00) && (addr >= IMEM_LO) && (addr <= IMEM_HI);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single PC, one outstanding imem request, hold
// buffer for D-stage stalls, pending-branch capture and redirect draining.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                req,
  input  logic                eret,
  input  logic [31:0]         epc,
  input  logic [2:0]          npc_sel,
  input  logic [31:0]         npc_target,
  fetch_unit_if.master        imem,
  output logic [31:0]         f_pc,
  output logic [31:0]         f_instr,
  output logic [4:0]          f_exccode,
  output logic                f_valid,
  output logic                f_bd
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_target_q, pend_target_d;
  fetch_hold_t  hold_q, hold_d;

  logic [31:0]  next_pc;
  logic [31:0]  redirect_pc;
  logic         pc_legal;
  logic         next_pc_legal;
  logic         redirect;
  logic         consume;
  logic         branch_in_d;

  pc_legal_check u_pc_check (
    .addr  (pc_q),
    .legal (pc_legal)
  );

  pc_legal_check u_next_pc_check (
    .addr  (next_pc),
    .legal (next_pc_legal)
  );

  assign branch_in_d = (npc_sel != 3'd0);
  assign redirect    = req | eret;
  assign redirect_pc = req ? PC_EXC : epc;

  // A D-resolved transfer wins; a branch seen during a bubble is replayed
  // from pend_target once its delay slot leaves F.
  always_comb begin
    if (branch_in_d)       next_pc = npc_target;
    else if (pend_valid_q) next_pc = pend_target_q;
    else                   next_pc = pc_q + 32'd4;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/case tree can leave it unassigned and infer a latch.
  always_comb begin
    f_valid   = 1'b0;
    f_instr   = 32'd0;
    f_exccode = EXC_NONE;
    if (!reset && !redirect) begin
      if (state_q == HOLD) begin
        f_valid   = 1'b1;
        f_instr   = hold_q.instr;
        f_exccode = hold_q.exccode;
      end else if (state_q == WAIT && imem.imem_rvalid) begin
        f_valid = 1'b1;
        f_instr = imem.imem_rdata;
      end
    end
  end

  assign consume = f_valid & en & ~req & ~eret;
  assign f_pc    = pc_q;
  assign f_bd    = ~reset & (pend_valid_q | branch_in_d);

  // Issuing next_pc in the consume cycle keeps one instruction per cycle
  // flowing at single-cycle memory latency.
  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_q;
    if (!reset) begin
      if (consume) begin
        imem.imem_req  = next_pc_legal;
        imem.imem_addr = next_pc;
      end else if (state_q == IDLE && !redirect) begin
        imem.imem_req = pc_legal;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    hold_d        = hold_q;

    if (redirect) begin
      pc_d         = redirect_pc;
      pend_valid_d = 1'b0;
      // An in-flight response must be swallowed before the new PC may issue.
      if ((state_q == WAIT || state_q == DRAIN) && !imem.imem_rvalid)
        state_d = DRAIN;
      else
        state_d = IDLE;
    end else if (consume) begin
      pc_d         = next_pc;
      pend_valid_d = 1'b0;
      state_d      = next_pc_legal ? WAIT : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (pc_legal) begin
            state_d = WAIT;
          end else begin
            state_d = HOLD;
            hold_d  = '{instr: 32'd0, exccode: EXC_ADEL};
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            state_d = HOLD;
            hold_d  = '{instr: imem.imem_rdata, exccode: EXC_NONE};
          end
        end
        HOLD:    state_d = HOLD;
        DRAIN:   if (imem.imem_rvalid) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      if (branch_in_d && en && !f_valid) begin
        pend_valid_d  = 1'b1;
        pend_target_d = npc_target;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= PC_RESET;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      hold_q        <= hold_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have: clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: en  in  1  F->D advance enable from hazard unit (0 = stall).
REQ-003 SHALL have: req  in  1  interrupt/exception redirect from CP0.
REQ-004 SHALL have: eret  in  1  ERET redirect; epc  in  32  return address.
REQ-005 SHALL have: npc_sel  in  3  D-stage control transfer (0 = sequential); npc_target  in  32  D-resolved target.
REQ-006 SHALL have: imem_req  out  1; imem_addr  out  32; imem_rvalid  in  1; imem_rdata  in  32.
REQ-007 SHALL have: f_pc  out  32; f_instr  out  32; f_exccode  out  5; f_valid  out  1; f_bd  out  1 (pending transfer, delay slot next).

Function
REQ-008 SHALL keep one PC register and allow at most one outstanding imem request; memory latency is >=1 cycle, and no rvalid arrives without a prior req.
REQ-009 SHALL use FSM states IDLE, WAIT, HOLD and DRAIN.
REQ-010 IDLE, legal pc: imem_req=1, imem_addr=pc, go to WAIT.
REQ-011 IDLE, illegal pc: no request; go to HOLD with instr=0 and exccode=5'd4 (AdEL).
REQ-012 Legal pc: word-aligned and within 0x0000_3000..0x0000_6FFC inclusive.
REQ-013 WAIT, rvalid=1: f_valid=1 and f_instr=imem_rdata in the same cycle; if en=0, capture rdata into a buffer and go to HOLD.
REQ-014 HOLD: f_valid=1, f_instr from the buffer; hold until consumed.
REQ-015 Consume = f_valid & en & ~req & ~eret; on consume, pc <= next_pc.
REQ-016 On consume, a legal next_pc SHALL issue in the same cycle (imem_req=1, imem_addr=next_pc) and the state is WAIT, giving 1 instr/cycle at 1-cycle latency; an illegal next_pc goes to IDLE.
REQ-017 next_pc SHALL be chosen in priority order: npc_sel!=0 -> npc_target; pend_valid -> pend_target; else pc+4 (32-bit wrap, no carry out).
REQ-018 If npc_sel!=0, en=1 and f_valid=0, SHALL set pend_valid and pend_target=npc_target so the branch survives a fetch bubble; pend_valid clears on the next consume.
REQ-019 f_bd SHALL equal pend_valid | (npc_sel!=0).
REQ-020 When f_valid=0, SHALL drive f_instr=0 and f_exccode=0 (bubble); f_pc=pc always.
REQ-021 req SHALL take priority over eret, which SHALL take priority over consume: pc <= 32'h0000_4180 (req) or epc (eret); clear pend_valid; f_valid=0 that cycle.
REQ-022 Redirect while WAIT with rvalid=0: go to DRAIN.
REQ-023 Redirect with rvalid=1 in the same cycle: discard the response and go to IDLE.
REQ-024 Redirect in any other state: go to IDLE.
REQ-025 DRAIN: imem_req=0; discard the response on rvalid and go to IDLE; a further redirect in DRAIN updates pc only.
REQ-026 Legal redirect targets SHALL be fetched from IDLE the next cycle; an illegal epc yields AdEL via REQ-011.

Reset
REQ-027 On reset: pc=0x0000_3000, state=IDLE, pend_valid=0, buffer=0.
REQ-028 Outputs during reset: f_valid=0, imem_req=0, f_instr=0, f_exccode=0, f_bd=0.
REQ-029 A response to a request issued before reset SHALL be ignored.
REQ-030 First request: addr 0x3000 on the first cycle after reset deasserts.

Structure
REQ-031 Shared package SHALL hold: PC_RESET=32'h3000, PC_EXC=32'h4180, IMEM_LO=32'h3000, IMEM_HI=32'h6FFC, EXC_ADEL=5'd4, and the FSM state enum.
REQ-032 SHALL contain one sub-module, pc_legal_check (combinational address legality test), used for both pc and next_pc.

Verification
REQ-033 Reset, memory latency 1, en=1 -> addresses 0x3000, 0x3004, 0x3008 on consecutive cycles, f_valid=1 each cycle.
REQ-034 en=0 for 3 cycles while rvalid pulses -> HOLD keeps instr stable; pc stays unchanged; no new request issued.
REQ-035 Branch in D (npc_sel=1, target 0x3100) during a fetch bubble -> delay slot at pc+4 fetched, then 0x3100; f_bd=1 meanwhile.
REQ-036 req asserted in WAIT with latency 3 -> DRAIN; stale rdata dropped; next imem_addr=0x4180.
REQ-037 eret with epc=0x3002 -> no imem_req; f_valid=1, f_instr=0, f_exccode=4, f_pc=0x3002.
REQ-038 pc=0x6FFC consumed -> next_pc 0x7000 illegal -> AdEL presented with f_pc=0x7000.
